// File: rtl/rtc_edit_ctrl.sv
// RTC edit controller: hour/date edit modes, then a six-register RTC write.
// Ports: clk/reset, buttons in, gated buttons out, BCD values, RTC write bus.
module rtc_edit_ctrl #(
  parameter int         TIMEOUT    = 1000000,
  parameter int         WR_TIMEOUT = 255,
  parameter logic [7:0] A_SEG      = 8'h21,
  parameter logic [7:0] A_MIN      = 8'h22,
  parameter logic [7:0] A_HORA     = 8'h23,
  parameter logic [7:0] A_DIA      = 8'h24,
  parameter logic [7:0] A_MES      = 8'h25,
  parameter logic [7:0] A_YEAR     = 8'h26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTc,
  input  logic       BTup,
  input  logic       BTdown,
  input  logic       BTl,
  input  logic       BTr,
  input  logic [7:0] horaC,
  input  logic [7:0] minC,
  input  logic [7:0] segC,
  input  logic [7:0] diaC,
  input  logic [7:0] mesC,
  input  logic [7:0] yearC,
  input  logic       busy,
  input  logic       done,
  output logic       EN_hora,
  output logic       EN_fecha,
  output logic       BTup_o,
  output logic       BTdown_o,
  output logic       BTl_o,
  output logic       BTr_o,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [1:0] modo,
  output logic       err
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int WW = $clog2(WR_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_RUN, S_EDIT_HORA, S_EDIT_FECHA, S_SNAP, S_WRITE, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      btn_q;
  logic [IW-1:0]   idle_q, idle_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [2:0]      idx_q, idx_d;
  logic            req_q, req_d;
  logic            err_q, err_d;
  logic [5:0][7:0] snap_q, snap_d;

  logic [4:0] btn, rise;
  logic       btc_rise, any_rise, idle_hit, wait_hit;
  logic       edit;

  assign btn      = {BTc, BTup, BTdown, BTl, BTr};
  assign rise     = btn & ~btn_q;
  assign btc_rise = rise[4];
  assign any_rise = |rise;
  assign idle_hit = (idle_q == IW'(TIMEOUT - 1));
  assign wait_hit = (wait_q == WW'(WR_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      btn_q   <= '0;
      idle_q  <= '0;
      wait_q  <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn;
      idle_q  <= idle_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      err_q   <= err_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = '0;
    wait_d  = wait_q;
    idx_d   = idx_q;
    req_d   = req_q;
    err_d   = err_q;
    snap_d  = snap_q;
    case (state_q)
      S_RUN: begin
        if (btc_rise) state_d = S_EDIT_HORA;
      end
      S_EDIT_HORA, S_EDIT_FECHA: begin
        // BTc edge wins over an expiring idle count
        if (btc_rise)
          state_d = (state_q == S_EDIT_HORA) ? S_EDIT_FECHA : S_SNAP;
        else if (idle_hit)
          state_d = S_RUN;
        else if (!any_rise)
          idle_d = idle_q + IW'(1);
      end
      S_SNAP: begin
        snap_d  = {yearC, mesC, diaC, horaC, minC, segC};
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = S_WRITE;
        if (!busy) begin
          req_d  = 1'b1;
          wait_d = '0;
        end
      end
      S_WRITE: begin
        if (req_q) begin
          if (done) begin
            req_d   = 1'b0;
            state_d = S_GAP;
          end else if (wait_hit) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_RUN;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end else if (!busy) begin
          req_d  = 1'b1;
          wait_d = '0;
        end
      end
      S_GAP: begin
        if (idx_q == 3'd5) begin
          state_d = S_RUN;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_WRITE;
          if (!busy) begin
            req_d  = 1'b1;
            wait_d = '0;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign edit     = (state_q == S_EDIT_HORA) || (state_q == S_EDIT_FECHA);
  assign EN_hora  = (state_q == S_EDIT_HORA);
  assign EN_fecha = (state_q == S_EDIT_FECHA);
  assign BTup_o   = edit & BTup;
  assign BTdown_o = edit & BTdown;
  assign BTl_o    = edit & BTl;
  assign BTr_o    = edit & BTr;
  assign wr_req   = req_q;
  assign err      = err_q;

  always_comb begin
    case (state_q)
      S_RUN:        modo = 2'd0;
      S_EDIT_HORA:  modo = 2'd1;
      S_EDIT_FECHA: modo = 2'd2;
      default:      modo = 2'd3;
    endcase
  end

  // address/data only shown while a request is live
  always_comb begin
    wr_addr = 8'h00;
    wr_data = 8'h00;
    if (req_q) begin
      case (idx_q)
        3'd0: begin wr_addr = A_SEG;  wr_data = snap_q[0]; end
        3'd1: begin wr_addr = A_MIN;  wr_data = snap_q[1]; end
        3'd2: begin wr_addr = A_HORA; wr_data = snap_q[2]; end
        3'd3: begin wr_addr = A_DIA;  wr_data = snap_q[3]; end
        3'd4: begin wr_addr = A_MES;  wr_data = snap_q[4]; end
        3'd5: begin wr_addr = A_YEAR; wr_data = snap_q[5]; end
        default: begin
          wr_addr = 8'h00;
          wr_data = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Bench for rtc_edit_ctrl: vector table plus multi-cycle write sequences.
// TIMEOUT=16, WR_TIMEOUT=8.
module tb_rtc_edit_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic BTc, BTup, BTdown, BTl, BTr;
  logic [7:0] horaC, minC, segC, diaC, mesC, yearC;
  logic busy, done;
  logic EN_hora, EN_fecha;
  logic BTup_o, BTdown_o, BTl_o, BTr_o;
  logic wr_req;
  logic [7:0] wr_addr, wr_data;
  logic [1:0] modo;
  logic err;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  rtc_edit_ctrl #(.TIMEOUT(16), .WR_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .BTc(BTc), .BTup(BTup), .BTdown(BTdown), .BTl(BTl), .BTr(BTr),
    .horaC(horaC), .minC(minC), .segC(segC),
    .diaC(diaC), .mesC(mesC), .yearC(yearC),
    .busy(busy), .done(done),
    .EN_hora(EN_hora), .EN_fecha(EN_fecha),
    .BTup_o(BTup_o), .BTdown_o(BTdown_o), .BTl_o(BTl_o), .BTr_o(BTr_o),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .modo(modo), .err(err)
  );

  typedef struct {
    logic       btc;
    logic [3:0] btn;
    logic       bsy;
    logic       dn;
    logic [1:0] modo;
    logic       enh;
    logic       enf;
    logic [3:0] bto;
    logic       req;
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[17];
  logic [7:0] ea[6];
  logic [7:0] ed[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_req) req_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    BTc = 0; BTup = 0; BTdown = 0; BTl = 0; BTr = 0;
    busy = 0; done = 0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic press();
    BTc = 1'b1;
    tick();
    BTc = 1'b0;
    tick();
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!wr_req && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!wr_req) begin
      errors++;
      $display("FAIL %s: wr_req got 0 expected 1 within 40 cycles", nm);
    end
  endtask

  task automatic xfer(input int i);
    wait_req("xfer_wait");
    chk("xfer_addr", wr_addr, ea[i]);
    chk("xfer_data", wr_data, ed[i]);
    tick();
    tick();
    chk("xfer_hold_req", wr_req, 1);
    chk("xfer_hold_addr", wr_addr, ea[i]);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("xfer_gap_req", wr_req, 0);
    tick();
    if (i < 5) chk("xfer_next_req", wr_req, 1);
    else chk("xfer_end_modo", modo, 0);
  endtask

  initial begin
    segC = 8'h45; minC = 8'h30; horaC = 8'h12;
    diaC = 8'h31; mesC = 8'h11; yearC = 8'h24;
    ea = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    ed = '{8'h45, 8'h30, 8'h12, 8'h31, 8'h11, 8'h24};

    tbl[0]  = '{0, 4'b0000, 0, 0, 2'd0, 0, 0, 4'b0000, 0, 8'h00, 8'h00};
    tbl[1]  = '{0, 4'b1000, 0, 0, 2'd0, 0, 0, 4'b0000, 0, 8'h00, 8'h00};
    tbl[2]  = '{1, 4'b0000, 0, 0, 2'd0, 0, 0, 4'b0000, 0, 8'h00, 8'h00};
    tbl[3]  = '{1, 4'b1000, 0, 0, 2'd1, 1, 0, 4'b1000, 0, 8'h00, 8'h00};
    tbl[4]  = '{0, 4'b0110, 0, 0, 2'd1, 1, 0, 4'b0110, 0, 8'h00, 8'h00};
    tbl[5]  = '{1, 4'b0001, 0, 0, 2'd1, 1, 0, 4'b0001, 0, 8'h00, 8'h00};
    tbl[6]  = '{1, 4'b0000, 0, 0, 2'd2, 0, 1, 4'b0000, 0, 8'h00, 8'h00};
    tbl[7]  = '{0, 4'b0010, 0, 0, 2'd2, 0, 1, 4'b0010, 0, 8'h00, 8'h00};
    tbl[8]  = '{1, 4'b0000, 0, 0, 2'd2, 0, 1, 4'b0000, 0, 8'h00, 8'h00};
    tbl[9]  = '{0, 4'b1111, 1, 0, 2'd3, 0, 0, 4'b0000, 0, 8'h00, 8'h00};
    tbl[10] = '{0, 4'b0000, 1, 0, 2'd3, 0, 0, 4'b0000, 0, 8'h00, 8'h00};
    tbl[11] = '{0, 4'b0000, 0, 1, 2'd3, 0, 0, 4'b0000, 0, 8'h00, 8'h00};
    tbl[12] = '{0, 4'b0000, 0, 0, 2'd3, 0, 0, 4'b0000, 1, 8'h21, 8'h45};
    tbl[13] = '{0, 4'b0000, 0, 1, 2'd3, 0, 0, 4'b0000, 1, 8'h21, 8'h45};
    tbl[14] = '{0, 4'b0000, 1, 0, 2'd3, 0, 0, 4'b0000, 0, 8'h00, 8'h00};
    tbl[15] = '{0, 4'b0000, 0, 0, 2'd3, 0, 0, 4'b0000, 0, 8'h00, 8'h00};
    tbl[16] = '{0, 4'b0000, 0, 0, 2'd3, 0, 0, 4'b0000, 1, 8'h22, 8'h30};

    // reset state
    reset = 1'b0;
    BTc = 0; BTup = 0; BTdown = 0; BTl = 0; BTr = 0;
    busy = 0; done = 0;
    #1;
    chk("rst_modo", modo, 0);
    chk("rst_req", wr_req, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_err", err, 0);
    chk("rst_en", {EN_hora, EN_fecha}, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      BTc = tbl[i].btc;
      {BTup, BTdown, BTl, BTr} = tbl[i].btn;
      busy = tbl[i].bsy;
      done = tbl[i].dn;
      #1;
      chk($sformatf("v%0d_modo", i), modo, tbl[i].modo);
      chk($sformatf("v%0d_enh", i), EN_hora, tbl[i].enh);
      chk($sformatf("v%0d_enf", i), EN_fecha, tbl[i].enf);
      chk($sformatf("v%0d_bto", i), {BTup_o, BTdown_o, BTl_o, BTr_o},
          tbl[i].bto);
      chk($sformatf("v%0d_req", i), wr_req, tbl[i].req);
      chk($sformatf("v%0d_addr", i), wr_addr, tbl[i].addr);
      chk($sformatf("v%0d_data", i), wr_data, tbl[i].data);
      tick();
    end

    // full six-register write
    do_reset();
    press(); press(); press();
    for (int i = 0; i < 6; i++) xfer(i);
    chk("full_err", err, 0);

    // edit timeout with no buttons
    do_reset();
    req_cnt = 0;
    BTc = 1'b1;
    tick();
    BTc = 1'b0;
    chk("to_enter", modo, 1);
    begin
      int n = 0;
      while (modo == 2'd1 && n < 40) begin
        tick();
        n++;
      end
      chk("to_cycles", n, 16);
    end
    chk("to_modo", modo, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("to_no_req", req_cnt, 0);

    // BTc edge in the cycle the idle count expires
    do_reset();
    BTc = 1'b1;
    tick();
    BTc = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("edge_still_hora", modo, 1);
    BTc = 1'b1;
    tick();
    BTc = 1'b0;
    chk("edge_modo", modo, 2);
    chk("edge_enf", EN_fecha, 1);
    chk("edge_enh", EN_hora, 0);

    // busy holds off the first request
    do_reset();
    busy = 1'b1;
    press(); press(); press();
    req_cnt = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("busy_no_req", req_cnt, 0);
    chk("busy_modo", modo, 3);
    busy = 1'b0;
    tick();
    chk("busy_req", wr_req, 1);
    chk("busy_addr", wr_addr, 8'h21);

    // done withheld -> write timeout
    do_reset();
    press(); press(); press();
    wait_req("wto_wait");
    begin
      int n = 0;
      while (wr_req && n < 30) begin
        tick();
        n++;
      end
      chk("wto_cycles", n, 8);
    end
    chk("wto_err", err, 1);
    chk("wto_req", wr_req, 0);
    chk("wto_modo", modo, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("wto_sticky", err, 1);
    press(); press(); press();
    chk("wto_clear", err, 0);

    // reset during transfer 3
    do_reset();
    press(); press(); press();
    xfer(0);
    xfer(1);
    wait_req("rst3_wait");
    chk("rst3_addr_pre", wr_addr, 8'h23);
    chk("rst3_data_pre", wr_data, 8'h12);
    #2;
    reset = 1'b0;
    #1;
    chk("rst3_req", wr_req, 0);
    chk("rst3_modo", modo, 0);
    chk("rst3_addr", wr_addr, 0);
    tick();
    tick();
    reset = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("rst3_no_req", req_cnt, 0);
    chk("rst3_modo_after", modo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
